// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings and the default-slave state encoding.
package ahbl_pkg;

  // HTRANS transfer types
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // HRESP encodings
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Default-slave FSM states
  localparam logic [1:0] DEF_OK   = 2'b00;
  localparam logic [1:0] DEF_ERR1 = 2'b01;
  localparam logic [1:0] DEF_ERR2 = 2'b10;

  // True for transfer types that require a slave response (NONSEQ/SEQ)
  function automatic logic htrans_active(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahbl_default_slave.sv
// Default slave for unmapped addresses: two-cycle AHB ERROR response.
//
// state    | meaning
// ---------+----------------------------------------------------------
// DEF_OK   | idle; zero-wait OKAY (hreadyout=1, hresp=0)
// DEF_ERR1 | first error cycle; stalls bus (hreadyout=0, hresp=1)
// DEF_ERR2 | second error cycle; completes transfer (hreadyout=1, hresp=1)
module ahbl_default_slave
  import ahbl_pkg::*;
(
  input  logic HCLK,
  input  logic HRESETn,
  input  logic i_req,
  input  logic i_hready,
  output logic o_hreadyout,
  output logic o_hresp
);

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;

  // Next-state logic; ERR1 always advances since the default slave owns HREADY then
  always_comb begin
    w_state_nxt = DEF_OK;
    case (r_state)
      DEF_OK:   w_state_nxt = (i_hready && i_req) ? DEF_ERR1 : DEF_OK;
      DEF_ERR1: w_state_nxt = DEF_ERR2;
      DEF_ERR2: w_state_nxt = i_req ? DEF_ERR1 : DEF_OK;
      default:  w_state_nxt = DEF_OK;
    endcase
  end

  // State register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= DEF_OK;
    else          r_state <= w_state_nxt;
  end

  // Outputs come straight from registered state, no input-to-output path
  assign o_hreadyout = (r_state != DEF_ERR1);
  assign o_hresp     = ((r_state == DEF_ERR1) || (r_state == DEF_ERR2)) ? HRESP_ERROR : HRESP_OKAY;

endmodule

// File: rtl/ahbl_decoder3.sv
// AHB-Lite three-way address decoder: address-phase selects, registered
// one-hot data-phase mux select, and the internal default slave in slot 2.
module ahbl_decoder3
  import ahbl_pkg::*;
#(
  parameter int            AW      = 32,
  parameter logic [AW-1:0] S0_BASE = 32'h0000_0000,
  parameter logic [AW-1:0] S0_MASK = 32'hF000_0000,
  parameter logic [AW-1:0] S1_BASE = 32'h1000_0000,
  parameter logic [AW-1:0] S1_MASK = 32'hF000_0000
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic [AW-1:0] HADDR,
  input  logic [1:0]    HTRANS,
  input  logic          HREADY,
  output logic          hsel_s0,
  output logic          hsel_s1,
  output logic [2:0]    dsel,
  output logic          def_hreadyout,
  output logic          def_hresp
);

  logic       w_m0;
  logic       w_m1;
  logic       w_mdef;
  logic       w_req;
  logic [2:0] r_dsel;

  // Slot 0 has priority where the two windows overlap
  assign w_m0   = ((HADDR & S0_MASK) == S0_BASE);
  assign w_m1   = ((HADDR & S1_MASK) == S1_BASE) && !w_m0;
  assign w_mdef = !w_m0 && !w_m1;

  // Selects are not gated by HTRANS; real slaves answer IDLE/BUSY themselves
  assign hsel_s0 = w_m0;
  assign hsel_s1 = w_m1;

  assign w_req = HREADY && w_mdef && htrans_active(HTRANS);

  // Data-phase select captured when the address phase completes, held across wait states
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)    r_dsel <= 3'b100;
    else if (HREADY) r_dsel <= {w_mdef, w_m1, w_m0};
  end

  assign dsel = r_dsel;

  ahbl_default_slave u_def (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .i_req       (w_req),
    .i_hready    (HREADY),
    .o_hreadyout (def_hreadyout),
    .o_hresp     (def_hresp)
  );

endmodule

// File: tb/tb_ahbl_decoder3.sv
module tb_ahbl_decoder3;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HREADY;
  logic        hsel_s0, hsel_s1;
  logic [2:0]  dsel;
  logic        def_hreadyout, def_hresp;

  int checks = 0;
  int errors = 0;

  ahbl_decoder3 dut (
    .HCLK          (HCLK),
    .HRESETn       (HRESETn),
    .HADDR         (HADDR),
    .HTRANS        (HTRANS),
    .HREADY        (HREADY),
    .hsel_s0       (hsel_s0),
    .hsel_s1       (hsel_s1),
    .dsel          (dsel),
    .def_hreadyout (def_hreadyout),
    .def_hresp     (def_hresp)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        rdy;
    logic        e_s0;
    logic        e_s1;
    logic [2:0]  e_dsel;
    logic        e_hro;
    logic        e_hresp;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: error cycle counter (0 = none, 1/2 = cycle of ERROR) and data-phase slot
  logic [2:0] m_dsel;
  int         m_err;

  initial begin
    logic [3:0]  reg_n;
    logic [31:0] a;
    logic [1:0]  t;
    logic        r;
    logic        unm;

    // expected values are those observed during the cycle the inputs are presented
    vecs[0]  = '{32'h0000_0040, 2'b10, 1'b1, 1, 0, 3'b100, 1, 0};
    vecs[1]  = '{32'h1000_0004, 2'b10, 1'b1, 0, 1, 3'b001, 1, 0};
    vecs[2]  = '{32'h1000_0004, 2'b00, 1'b0, 0, 1, 3'b010, 1, 0};
    vecs[3]  = '{32'h1000_0004, 2'b00, 1'b0, 0, 1, 3'b010, 1, 0};
    vecs[4]  = '{32'h1000_0004, 2'b00, 1'b0, 0, 1, 3'b010, 1, 0};
    vecs[5]  = '{32'h8000_0000, 2'b10, 1'b1, 0, 0, 3'b010, 1, 0};
    vecs[6]  = '{32'h0000_0000, 2'b00, 1'b0, 1, 0, 3'b100, 0, 1};
    vecs[7]  = '{32'h0000_0000, 2'b00, 1'b1, 1, 0, 3'b100, 1, 1};
    vecs[8]  = '{32'h8000_0000, 2'b00, 1'b1, 0, 0, 3'b001, 1, 0};
    vecs[9]  = '{32'h8000_0000, 2'b10, 1'b1, 0, 0, 3'b100, 1, 0};
    vecs[10] = '{32'h9000_0000, 2'b10, 1'b0, 0, 0, 3'b100, 0, 1};
    vecs[11] = '{32'h9000_0000, 2'b10, 1'b1, 0, 0, 3'b100, 1, 1};
    vecs[12] = '{32'h0000_0000, 2'b00, 1'b0, 1, 0, 3'b100, 0, 1};
    vecs[13] = '{32'h0000_0000, 2'b00, 1'b1, 1, 0, 3'b100, 1, 1};
    vecs[14] = '{32'h0000_0000, 2'b00, 1'b1, 1, 0, 3'b001, 1, 0};

    HRESETn = 1'b0;
    HADDR   = 32'h8000_0000;
    HTRANS  = 2'b00;
    HREADY  = 1'b1;
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;

    @(negedge HCLK);
    chk("reset_dsel", {29'd0, dsel}, 32'h4);
    chk("reset_hro", {31'd0, def_hreadyout}, 32'h1);
    chk("reset_hresp", {31'd0, def_hresp}, 32'h0);
    @(posedge HCLK); #1;

    for (int i = 0; i < 15; i++) begin
      HADDR  = vecs[i].addr;
      HTRANS = vecs[i].trans;
      HREADY = vecs[i].rdy;
      @(negedge HCLK);
      chk($sformatf("v%0d_hsel_s0", i), {31'd0, hsel_s0}, {31'd0, vecs[i].e_s0});
      chk($sformatf("v%0d_hsel_s1", i), {31'd0, hsel_s1}, {31'd0, vecs[i].e_s1});
      chk($sformatf("v%0d_dsel", i), {29'd0, dsel}, {29'd0, vecs[i].e_dsel});
      chk($sformatf("v%0d_hro", i), {31'd0, def_hreadyout}, {31'd0, vecs[i].e_hro});
      chk($sformatf("v%0d_hresp", i), {31'd0, def_hresp}, {31'd0, vecs[i].e_hresp});
      @(posedge HCLK); #1;
    end

    // Reset pulsed while in the first error cycle
    HADDR = 32'h8000_0000; HTRANS = 2'b10; HREADY = 1'b1;
    @(posedge HCLK); #1;
    HTRANS = 2'b00; HREADY = 1'b0;
    chk("err1_before_rst_hro", {31'd0, def_hreadyout}, 32'h0);
    #2 HRESETn = 1'b0;
    #1;
    chk("async_rst_dsel", {29'd0, dsel}, 32'h4);
    chk("async_rst_hro", {31'd0, def_hreadyout}, 32'h1);
    chk("async_rst_hresp", {31'd0, def_hresp}, 32'h0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1; HREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      chk($sformatf("post_rst%0d_hresp", i), {31'd0, def_hresp}, 32'h0);
      chk($sformatf("post_rst%0d_hro", i), {31'd0, def_hreadyout}, 32'h1);
      @(posedge HCLK); #1;
    end

    // Randomized traffic against the reference model; HREADY follows the response mux
    m_dsel = 3'b100;
    m_err  = 0;
    for (int c = 0; c < 400; c++) begin
      case ($urandom_range(0, 3))
        0:       reg_n = 4'h0;
        1:       reg_n = 4'h1;
        default: reg_n = 4'($urandom_range(2, 15));
      endcase
      a = {reg_n, 28'($urandom)};
      t = 2'($urandom_range(0, 3));
      if (m_dsel[2]) r = (m_err != 1);
      else           r = ($urandom_range(0, 3) != 0);
      unm = (a[31:28] >= 4'h2);
      HADDR = a; HTRANS = t; HREADY = r;
      @(negedge HCLK);
      chk($sformatf("rnd%0d_hsel_s0", c), {31'd0, hsel_s0}, {31'd0, a[31:28] == 4'h0});
      chk($sformatf("rnd%0d_hsel_s1", c), {31'd0, hsel_s1}, {31'd0, a[31:28] == 4'h1});
      chk($sformatf("rnd%0d_dsel", c), {29'd0, dsel}, {29'd0, m_dsel});
      chk($sformatf("rnd%0d_hro", c), {31'd0, def_hreadyout}, {31'd0, m_err != 1});
      chk($sformatf("rnd%0d_hresp", c), {31'd0, def_hresp}, {31'd0, m_err != 0});
      if (m_err == 1)              m_err = 2;
      else if (r && unm && t[1])   m_err = 1;
      else                         m_err = 0;
      if (r) m_dsel = unm ? 3'b100 : ((a[31:28] == 4'h0) ? 3'b001 : 3'b010);
      @(posedge HCLK); #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahbl_decoder3.md
# ahbl_decoder3

AHB-Lite address decoder and default slave for a three-way slave port. It decodes the master's address phase into slave selects. It registers a one-hot data-phase select that drives the select inputs of the downstream 3:1 AND-OR response mux (HRDATA/HREADYOUT/HRESP). Slots 0 and 1 are real slaves; slot 2 is an internal default slave. The default slave returns the AHB two-cycle ERROR response for active transfers to unmapped addresses.

## Interface
- AW, 32: address width.
- S0_BASE, 32'h0000_0000: slot 0 base; compared after masking.
- S0_MASK, 32'hF000_0000: slot 0 address mask.
- S1_BASE, 32'h1000_0000: slot 1 base.
- S1_MASK, 32'hF000_0000: slot 1 mask.

Ports:
- HCLK  in  1  single clock; all state on rising edge.
- HRESETn  in  1  asynchronous, active-low reset.
- HADDR  in  AW  address-phase address.
- HTRANS  in  2  transfer type; bit 1 set = NONSEQ/SEQ (active).
- HREADY  in  1  bus ready, taken from the response mux output.
- hsel_s0  out  1  address-phase select, slot 0 (combinational).
- hsel_s1  out  1  address-phase select, slot 1 (combinational).
- dsel  out  3  registered one-hot data-phase select; bit n drives mux sel n.
- def_hreadyout  out  1  default-slave HREADYOUT, feeds mux in2.
- def_hresp  out  1  default-slave HRESP (1 = ERROR), feeds mux in2.

## Operation
- Decode:
  - m0 = ((HADDR & S0_MASK) == S0_BASE).
  - m1 = ((HADDR & S1_MASK) == S1_BASE) & ~m0. Slot 0 wins on overlap.
  - mdef = ~m0 & ~m1.
  - hsel_s0 = m0 and hsel_s1 = m1. Neither is gated by HTRANS: a selected slave answers IDLE/BUSY itself.
- Data-phase select:
  - On each edge with HREADY=1, dsel <= {mdef, m1, m0}.
  - With HREADY=0, dsel holds.
  - dsel is always exactly one-hot.
- Default-slave FSM, states DEF_OK, DEF_ERR1, DEF_ERR2:
  - DEF_OK: def_hreadyout=1, def_hresp=0. If HREADY=1 & mdef & HTRANS[1], go to DEF_ERR1; else stay.
  - DEF_ERR1: def_hreadyout=0, def_hresp=1. Always go to DEF_ERR2. HTRANS changes during this cycle are ignored.
  - DEF_ERR2: def_hreadyout=1, def_hresp=1. HREADY is 1 here because the default slave owns the bus. Go to DEF_ERR1 if mdef & HTRANS[1]; else go to DEF_OK.
- IDLE or BUSY to an unmapped address gets a zero-wait OKAY and stays in DEF_OK.
- FSM outputs are decoded from registered state only; there is no combinational path from inputs.

## Timing
- Reset (asynchronous, HRESETn low): dsel=3'b100, FSM=DEF_OK, def_hreadyout=1, def_hresp=0. The mux therefore presents HREADY=1, OKAY out of reset.
- hsel_s0/hsel_s1: zero latency from HADDR.
- dsel: one cycle after the address phase that completes with HREADY=1. It stays valid for the entire data phase, including wait states.
- Error response: exactly 2 cycles (ERR1 then ERR2), starting in the cycle after the unmapped active address phase.
- Back-to-back unmapped active transfers: ERR1, ERR2, ERR1, ERR2 with no DEF_OK gap.
- Wait states from a real slave (HREADY=0): dsel and FSM hold; no new address is sampled.
- Reset asserted mid-error: return immediately to the reset values. No residual ERROR is issued after release.

## Structure
- Shared package ahbl_pkg:
  - HTRANS encodings: IDLE=2'b00, BUSY=2'b01, NONSEQ=2'b10, SEQ=2'b11.
  - HRESP encodings: OKAY=0, ERROR=1.
  - Default-slave state encoding.
- Natural sub-module: ahbl_default_slave, containing the FSM plus def_hreadyout/def_hresp. Its inputs are HCLK, HRESETn, a qualified request (HREADY & mdef & HTRANS[1]), and HREADY. The decoder top keeps the match logic and the dsel register.

## Test plan
- Reset, then NONSEQ to 32'h0000_0040 with HREADY=1 → hsel_s0=1 in the same cycle; dsel=3'b001 the next cycle; def_hresp=0.
- NONSEQ to 32'h1000_0004, then slot 1 stalls HREADY=0 for 3 cycles → dsel=3'b010 held all 3 cycles; FSM stays DEF_OK.
- NONSEQ to 32'h8000_0000 (unmapped) → dsel=3'b100. Next cycle: def_hreadyout=0, def_hresp=1. Following cycle: def_hreadyout=1, def_hresp=1. Then DEF_OK.
- IDLE to 32'h8000_0000 → dsel=3'b100, def_hreadyout=1, def_hresp=0 throughout (zero-wait OKAY).
- Two consecutive unmapped NONSEQs, the second presented during ERR2 → response sequence ERR1, ERR2, ERR1, ERR2, then OKAY.
- HRESETn pulsed low during DEF_ERR1 → outputs asynchronously return to dsel=3'b100, def_hreadyout=1, def_hresp=0.
